// File: rtl/lsu_req_ctrl_pkg.sv
// Shared encodings for the load/store request controller: access widths,
// FSM states, address-map/timeout defaults and the alignment rule.
package lsu_req_ctrl_pkg;

    localparam logic [1:0]  MEM_W_BYTE = 2'b00;
    localparam logic [1:0]  MEM_W_HALF = 2'b01;
    localparam logic [1:0]  MEM_W_WORD = 2'b10;

    localparam logic [31:0] BUS_BASE_DEFAULT    = 32'h2000_0000;
    localparam logic [7:0]  BUS_TIMEOUT_DEFAULT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DC_WAIT  = 2'd1,
        ST_BUS_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } lsu_state_e;

    // Width 2'b11 falls into the default arm and is aligned like a word.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            MEM_W_BYTE: is_misaligned = 1'b0;
            MEM_W_HALF: is_misaligned = off[0];
            default:    is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: load lane extract + sign/zero extend, store
// replicate + byte strobe generation.
module lsu_data_align
    import lsu_req_ctrl_pkg::*;
(
    input  logic [1:0]  ld_off_i,
    input  logic [1:0]  ld_width_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o,
    input  logic [1:0]  st_off_i,
    input  logic [1:0]  st_width_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  st_strb_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = ld_word_i[8*ld_off_i +: 8];
        lane_h = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_width_i)
            MEM_W_BYTE: ld_data_o = {{24{~ld_unsigned_i & lane_b[7]}}, lane_b};
            MEM_W_HALF: ld_data_o = {{16{~ld_unsigned_i & lane_h[15]}}, lane_h};
            default:    ld_data_o = ld_word_i;
        endcase
    end

    always_comb begin
        case (st_width_i)
            MEM_W_BYTE: begin
                st_data_o = {4{st_data_i[7:0]}};
                st_strb_o = 4'b0001 << st_off_i;
            end
            MEM_W_HALF: begin
                st_data_o = {2{st_data_i[15:0]}};
                st_strb_o = 4'b0011 << st_off_i;
            end
            default: begin
                st_data_o = st_data_i;
                st_strb_o = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/lsu_req_ctrl.sv
// LSU request FSM: routes aligned ops to Dcache or bus, holds the pipeline
// until ready/ack/timeout, then returns one RESP cycle with extended load data.
module lsu_req_ctrl
    import lsu_req_ctrl_pkg::*;
#(
    parameter logic [31:0] BUS_BASE    = BUS_BASE_DEFAULT,
    parameter logic [7:0]  BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mtype_i,
    input  logic        ex_mem_rw_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic [31:0] ex_mem_wr_data_i,
    input  logic        ex_mem_rdtype_i,
    input  logic        flush_i,
    output logic        dc_req_o,
    output logic        dc_rw_o,
    output logic [31:0] dc_addr_o,
    output logic [31:0] dc_wdata_o,
    output logic [3:0]  dc_wstrb_o,
    input  logic        dc_ready_i,
    input  logic [31:0] dc_rdata_i,
    output logic        bus_req_o,
    output logic        bus_rw_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misalign_o,
    output logic        lsu_err_o
);

    lsu_state_e  state_q, state_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  width_q, width_d;
    logic        rdtype_q, rdtype_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        op_vld;
    logic        op_misal;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    // Gated by rst_n so a held op cannot raise stall/misalign while in reset.
    assign op_vld   = rst_n & ex_mtype_i & ~flush_i;
    assign op_misal = is_misaligned(ex_mem_width_i, ex_mem_addr_i[1:0]);

    lsu_data_align u_align (
        .ld_off_i      (addr_q[1:0]),
        .ld_width_i    (width_q),
        .ld_unsigned_i (rdtype_q),
        .ld_word_i     (rdata_q),
        .ld_data_o     (ld_data),
        .st_off_i      (ex_mem_addr_i[1:0]),
        .st_width_i    (ex_mem_width_i),
        .st_data_i     (ex_mem_wr_data_i),
        .st_data_o     (st_data),
        .st_strb_o     (st_strb)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        width_d  = width_q;
        rdtype_d = rdtype_q;
        drop_d   = drop_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        dc_req_o       = 1'b0;
        dc_rw_o        = 1'b0;
        dc_addr_o      = '0;
        dc_wdata_o     = '0;
        dc_wstrb_o     = '0;
        bus_req_o      = 1'b0;
        bus_rw_o       = 1'b0;
        bus_addr_o     = '0;
        bus_wdata_o    = '0;
        bus_wstrb_o    = '0;
        lsu_stall_o    = 1'b0;
        lsu_valid_o    = 1'b0;
        lsu_rdata_o    = '0;
        lsu_misalign_o = 1'b0;
        lsu_err_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_vld && op_misal) begin
                    lsu_valid_o    = 1'b1;
                    lsu_misalign_o = 1'b1;
                end else if (op_vld) begin
                    lsu_stall_o = 1'b1;
                    rw_d        = ex_mem_rw_i;
                    addr_d      = ex_mem_addr_i;
                    wdata_d     = st_data;
                    wstrb_d     = st_strb;
                    width_d     = ex_mem_width_i;
                    rdtype_d    = ex_mem_rdtype_i;
                    drop_d      = 1'b0;
                    err_d       = 1'b0;
                    rdata_d     = '0;
                    cnt_d       = '0;
                    state_d     = (ex_mem_addr_i < BUS_BASE) ? ST_DC_WAIT : ST_BUS_WAIT;
                end
            end
            ST_DC_WAIT: begin
                lsu_stall_o = 1'b1;
                dc_req_o    = 1'b1;
                dc_rw_o     = rw_q;
                dc_addr_o   = addr_q;
                dc_wdata_o  = wdata_q;
                dc_wstrb_o  = wstrb_q;
                if (flush_i) drop_d = 1'b1;
                if (dc_ready_i) begin
                    rdata_d = dc_rdata_i;
                    state_d = ST_RESP;
                end
            end
            ST_BUS_WAIT: begin
                lsu_stall_o = 1'b1;
                bus_req_o   = (cnt_q == 8'd0);
                bus_rw_o    = rw_q;
                bus_addr_o  = addr_q;
                bus_wdata_o = wdata_q;
                bus_wstrb_o = wstrb_q;
                if (flush_i) drop_d = 1'b1;
                if (bus_ack_i || bus_err_i) begin
                    err_d   = bus_err_i;
                    if (!bus_err_i) rdata_d = bus_rdata_i;
                    state_d = ST_RESP;
                end else if ((cnt_q + 8'd1) == BUS_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                lsu_valid_o = ~drop_q;
                lsu_err_o   = err_q & ~drop_q;
                lsu_rdata_o = (~rw_q & ~err_q & ~drop_q) ? ld_data : 32'd0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            width_q  <= '0;
            rdtype_q <= 1'b0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            width_q  <= width_d;
            rdtype_q <= rdtype_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Directed bench for lsu_req_ctrl: a per-cycle expectation timeline built from
// transaction descriptions, checked at every negedge, plus literal pins.
module tb_lsu_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_mtype_i, ex_mem_rw_i, ex_mem_rdtype_i, flush_i;
    logic [31:0] ex_mem_addr_i, ex_mem_wr_data_i;
    logic [1:0]  ex_mem_width_i;
    logic        dc_req_o, dc_rw_o, dc_ready_i;
    logic [31:0] dc_addr_o, dc_wdata_o, dc_rdata_i;
    logic [3:0]  dc_wstrb_o;
    logic        bus_req_o, bus_rw_o, bus_ack_i, bus_err_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_wstrb_o;
    logic        lsu_stall_o, lsu_valid_o, lsu_misalign_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;

    lsu_req_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mtype_i(ex_mtype_i), .ex_mem_rw_i(ex_mem_rw_i), .ex_mem_addr_i(ex_mem_addr_i),
        .ex_mem_width_i(ex_mem_width_i), .ex_mem_wr_data_i(ex_mem_wr_data_i),
        .ex_mem_rdtype_i(ex_mem_rdtype_i), .flush_i(flush_i),
        .dc_req_o(dc_req_o), .dc_rw_o(dc_rw_o), .dc_addr_o(dc_addr_o), .dc_wdata_o(dc_wdata_o),
        .dc_wstrb_o(dc_wstrb_o), .dc_ready_i(dc_ready_i), .dc_rdata_i(dc_rdata_i),
        .bus_req_o(bus_req_o), .bus_rw_o(bus_rw_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o), .bus_ack_i(bus_ack_i),
        .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_valid_o(lsu_valid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_misalign_o(lsu_misalign_o), .lsu_err_o(lsu_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle; field groups are only checked when flagged.
    logic        e_stall, e_valid, e_misal, e_err, e_dc_req, e_bus_req;
    logic        e_chk_rd, e_dc_fld, e_bus_fld, e_dc_wr, e_bus_wr;
    logic [31:0] e_rdata;
    logic        e_rw;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    int          n_dcq, n_busq, n_stall;
    logic [3:0]  cap_bstrb;
    logic [31:0] cap_bdata;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall", 32'(lsu_stall_o), 32'(e_stall));
            cmp("valid", 32'(lsu_valid_o), 32'(e_valid));
            cmp("misalign", 32'(lsu_misalign_o), 32'(e_misal));
            cmp("err", 32'(lsu_err_o), 32'(e_err));
            cmp("dc_req", 32'(dc_req_o), 32'(e_dc_req));
            cmp("bus_req", 32'(bus_req_o), 32'(e_bus_req));
            if (e_chk_rd) cmp("rdata", lsu_rdata_o, e_rdata);
            if (e_dc_fld) begin
                cmp("dc_rw", 32'(dc_rw_o), 32'(e_rw));
                cmp("dc_addr", dc_addr_o, e_addr);
            end
            if (e_dc_wr) begin
                cmp("dc_wdata", dc_wdata_o, e_wdata);
                cmp("dc_wstrb", 32'(dc_wstrb_o), 32'(e_wstrb));
            end
            if (e_bus_fld) begin
                cmp("bus_rw", 32'(bus_rw_o), 32'(e_rw));
                cmp("bus_addr", bus_addr_o, e_addr);
            end
            if (e_bus_wr) begin
                cmp("bus_wdata", bus_wdata_o, e_wdata);
                cmp("bus_wstrb", 32'(bus_wstrb_o), 32'(e_wstrb));
            end
        end
        if (dc_req_o) n_dcq++;
        if (bus_req_o) begin
            n_busq++;
            cap_bstrb = bus_wstrb_o;
            cap_bdata = bus_wdata_o;
        end
        if (lsu_stall_o) n_stall++;
    end

    // Reference rules written from the architectural description.
    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] w, input logic uns);
        logic [31:0] sh;
        sh = word >> (8 * off);
        if (w == 2'b00) return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        if (w == 2'b01) return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        return word;
    endfunction

    function automatic logic [3:0] f_strb(input logic [1:0] w, input logic [1:0] off);
        if (w == 2'b00) return 4'b0001 << off;
        if (w == 2'b01) return 4'b0011 << off;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_wrep(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'b00) return {4{d[7:0]}};
        if (w == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_zero();
        e_stall = 0; e_valid = 0; e_misal = 0; e_err = 0; e_dc_req = 0; e_bus_req = 0;
        e_chk_rd = 0; e_dc_fld = 0; e_bus_fld = 0; e_dc_wr = 0; e_bus_wr = 0;
        e_rdata = 0; e_rw = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
    endtask

    // Everything, including request fields, must read as zero.
    task automatic exp_all_zero();
        exp_zero();
        e_chk_rd = 1; e_dc_fld = 1; e_bus_fld = 1; e_dc_wr = 1; e_bus_wr = 1;
    endtask

    task automatic in_idle();
        ex_mtype_i = 0; ex_mem_rw_i = 0; ex_mem_addr_i = 0; ex_mem_width_i = 0;
        ex_mem_wr_data_i = 0; ex_mem_rdtype_i = 0; flush_i = 0;
        dc_ready_i = 0; bus_ack_i = 0; bus_err_i = 0;
        dc_rdata_i = $urandom(); bus_rdata_i = $urandom();
    endtask

    task automatic idle();
        step();
        in_idle();
        exp_zero();
    endtask

    task automatic clr_counts();
        n_dcq = 0; n_busq = 0; n_stall = 0; cap_bstrb = 0; cap_bdata = 0;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp(nm, act, exp);
    endtask

    // resp: 0 ack, 1 bus error, 2 silent (wait out the timeout). flush_at: wait-cycle index or -1.
    task automatic do_op(input logic rw, input logic [31:0] addr, input logic [1:0] w,
                         input logic [31:0] wd, input logic uns, input int n_wait,
                         input logic [31:0] rd, input int resp, input int flush_at);
        logic is_bus, drop, err, last;
        is_bus = (addr >= 32'h2000_0000);
        drop   = 0;
        step();
        in_idle();
        ex_mtype_i = 1; ex_mem_rw_i = rw; ex_mem_addr_i = addr; ex_mem_width_i = w;
        ex_mem_wr_data_i = wd; ex_mem_rdtype_i = uns;
        exp_zero();
        e_stall = 1;
        for (int i = 0; i < n_wait; i++) begin
            step();
            in_idle();
            last = (i == n_wait - 1);
            exp_zero();
            e_stall = 1;
            e_rw = rw; e_addr = addr; e_wdata = f_wrep(w, wd); e_wstrb = f_strb(w, addr[1:0]);
            if (i == flush_at) begin
                flush_i = 1;
                drop = 1;
            end
            if (is_bus) begin
                e_bus_req = (i == 0); e_bus_fld = 1; e_bus_wr = rw;
                if (last) begin
                    bus_ack_i = (resp == 0); bus_err_i = (resp == 1); bus_rdata_i = rd;
                end
            end else begin
                e_dc_req = 1; e_dc_fld = 1; e_dc_wr = rw;
                if (last) begin
                    dc_ready_i = 1; dc_rdata_i = rd;
                end
            end
        end
        step();
        in_idle();
        exp_zero();
        err = is_bus && (resp != 0);
        e_valid  = !drop;
        e_err    = err && !drop;
        e_chk_rd = !(err || drop);
        e_rdata  = rw ? 32'd0 : f_load(rd, addr[1:0], w, uns);
    endtask

    task automatic misal(input logic [31:0] addr, input logic [1:0] w);
        step();
        in_idle();
        ex_mtype_i = 1; ex_mem_addr_i = addr; ex_mem_width_i = w;
        exp_zero();
        e_valid = 1; e_misal = 1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        in_idle();
        rst_n = 0;
        exp_zero();
        clr_counts();
        step();
        step();
        exp_all_zero();
        chk_en = 1;
        step();
        rst_n = 1;
        exp_all_zero();
        idle();

        // Signed byte, Dcache ready on second wait cycle.
        clr_counts();
        do_op(0, 32'h0000_1003, 2'b00, 0, 0, 2, 32'h80AA_BBCC, 0, -1);
        #2;
        lit("lb_rdata_lit", lsu_rdata_o, 32'hFFFF_FF80);
        lit("lb_valid_lit", 32'(lsu_valid_o), 1);
        lit("lb_dcreq_cycles", n_dcq, 2);
        idle();

        // Store half to bus, ack on third wait cycle.
        clr_counts();
        do_op(1, 32'h2000_0002, 2'b01, 32'h0000_1234, 0, 3, 0, 0, -1);
        #2;
        lit("sh_busreq_pulses", n_busq, 1);
        lit("sh_wstrb_lit", 32'(cap_bstrb), 32'hC);
        lit("sh_wdata_lit", cap_bdata, 32'h1234_1234);
        lit("sh_stall_cycles", n_stall, 4);
        idle();

        clr_counts();
        misal(32'h0000_0006, 2'b10);
        misal(32'h2000_0001, 2'b01);
        lit("misal_no_req", n_dcq + n_busq + n_stall, 0);

        // Silent bus: timeout after 255 wait cycles.
        clr_counts();
        do_op(0, 32'h3000_0000, 2'b01, 0, 1, 255, 0, 2, -1);
        #2;
        lit("to_err_lit", 32'(lsu_err_o), 1);
        lit("to_stall_cycles", n_stall, 256);
        idle();

        // Back-to-back: second op accepted the cycle after RESP.
        clr_counts();
        do_op(0, 32'h0000_0100, 2'b10, 0, 0, 1, 32'hDEAD_BEEF, 0, -1);
        do_op(1, 32'h2000_0000, 2'b10, 32'hCAFE_F00D, 0, 1, 0, 0, -1);
        #2;
        lit("b2b_dc_reqs", n_dcq, 1);
        lit("b2b_bus_reqs", n_busq, 1);
        idle();

        do_op(0, 32'h0000_1001, 2'b00, 0, 1, 1, 32'h1234_56F0, 0, -1);
        idle();
        do_op(0, 32'h0000_0002, 2'b01, 0, 0, 2, 32'h9ABC_0000, 0, -1);
        do_op(0, 32'h2000_0010, 2'b11, 0, 0, 2, 32'h8765_4321, 0, -1);
        do_op(1, 32'h0000_0001, 2'b00, 32'h0000_00A5, 0, 1, 0, 0, -1);
        idle();
        do_op(0, 32'h2000_0004, 2'b10, 0, 0, 2, 32'h1111_1111, 1, -1);
        idle();

        // Flush while waiting on Dcache: completes silently.
        do_op(0, 32'h0000_0202, 2'b01, 0, 0, 3, 32'h8001_0000, 0, 1);
        #2;
        lit("flush_valid_lit", 32'(lsu_valid_o), 0);
        idle();

        // Flush in the same cycle as an op: nothing accepted.
        step();
        in_idle();
        ex_mtype_i = 1; flush_i = 1; ex_mem_addr_i = 32'h0000_0040; ex_mem_width_i = 2'b10;
        exp_zero();
        idle();

        // Reset while waiting on the bus: transaction abandoned.
        clr_counts();
        step();
        in_idle();
        ex_mtype_i = 1; ex_mem_addr_i = 32'h2000_0008; ex_mem_width_i = 2'b10;
        exp_zero();
        e_stall = 1;
        step();
        in_idle();
        exp_zero();
        e_stall = 1; e_bus_req = 1; e_bus_fld = 1; e_addr = 32'h2000_0008;
        step();
        in_idle();
        exp_zero();
        e_stall = 1; e_bus_fld = 1; e_addr = 32'h2000_0008;
        step();
        rst_n = 0;
        chk_en = 0;
        step();
        rst_n = 1;
        chk_en = 1;
        exp_all_zero();
        step();
        in_idle();
        bus_ack_i = 1;
        exp_all_zero();
        for (int i = 0; i < 3; i++) begin
            step();
            in_idle();
            exp_all_zero();
        end
        lit("rst_bus_reqs", n_busq, 1);

        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_req_ctrl.md
LSU_REQ_CTRL -- requirements
Module: lsu_req_ctrl

Interface
REQ-001 SHALL have parameter BUS_BASE, 32'h2000_0000, lowest address routed to bus (below it routed to Dcache).
REQ-002 SHALL have parameter BUS_TIMEOUT, 8'd255, max BUS_WAIT cycles before error.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ex_mtype_i in 1 memory op present; ex_mem_rw_i in 1 (0 read, 1 write); ex_mem_addr_i in 32; ex_mem_width_i in 2 (00 byte, 01 half, 10 word); ex_mem_wr_data_i in 32; ex_mem_rdtype_i in 1 (0 signed, 1 unsigned).
REQ-006 flush_i in 1 discard current op result.
REQ-007 dc_req_o out 1; dc_rw_o out 1; dc_addr_o out 32; dc_wdata_o out 32; dc_wstrb_o out 4; dc_ready_i in 1; dc_rdata_i in 32 (word-aligned).
REQ-008 bus_req_o out 1; bus_rw_o out 1; bus_addr_o out 32; bus_wdata_o out 32; bus_wstrb_o out 4; bus_ack_i in 1; bus_err_i in 1; bus_rdata_i in 32 (word-aligned).
REQ-009 lsu_stall_o out 1 to fc; lsu_valid_o out 1 op complete; lsu_rdata_o out 32 extended load data; lsu_misalign_o out 1; lsu_err_o out 1.

Function
REQ-010 FSM states SHALL be IDLE, DC_WAIT, BUS_WAIT, RESP.
REQ-011 IDLE: accept when ex_mtype_i=1, flush_i=0, access aligned; go DC_WAIT if addr < BUS_BASE, else BUS_WAIT; latch rw/addr/wdata/wstrb/width/rdtype.
REQ-012 Misaligned (half addr[0]=1; word addr[1:0]!=0) in IDLE: no request, lsu_misalign_o=1 and lsu_valid_o=1 for that single cycle, stay IDLE.
REQ-013 lsu_stall_o SHALL be 1 combinationally in IDLE accept cycle and throughout DC_WAIT/BUS_WAIT; 0 in RESP and otherwise.
REQ-014 dc_req_o SHALL be 1 for every DC_WAIT cycle, request fields held stable; transition to RESP on cycle dc_ready_i=1.
REQ-015 bus_req_o SHALL be a one-cycle pulse on first BUS_WAIT cycle only; fields held stable throughout BUS_WAIT.
REQ-016 BUS_WAIT: bus_ack_i or bus_err_i -> RESP; 8-bit counter reaching BUS_TIMEOUT -> RESP with error; bus_err_i or timeout sets lsu_err_o in RESP.
REQ-017 RESP lasts exactly one cycle: lsu_valid_o=1 (unless dropped), lsu_rdata_o valid for reads, then IDLE.
REQ-018 Latency: accept cycle T, request visible T+1, ready/ack at cycle N >= T+1, RESP at N+1.
REQ-019 Reads: select lane by latched addr[1:0]; byte/half sign-extend if rdtype=0, zero-extend if 1; word unchanged.
REQ-020 Writes: data replicated to all lanes; wstrb byte=0001<<addr[1:0], half=0011<<addr[1:0], word=1111; write RESP lsu_rdata_o=0.
REQ-021 flush_i=1 in DC_WAIT/BUS_WAIT SHALL set drop flag; transaction still completes; RESP then lsu_valid_o=0, lsu_err_o=0.
REQ-022 flush_i=1 and ex_mtype_i=1 same IDLE cycle: no accept, no stall.
REQ-023 Read data SHALL be captured on dc_ready_i/bus_ack_i cycle and held through RESP.
REQ-024 Width 11 SHALL be treated as word.

Reset
REQ-025 rst_n=0 SHALL force IDLE, clear drop flag, timeout counter 0; all outputs 0 next cycle.
REQ-026 Reset mid DC_WAIT/BUS_WAIT SHALL abandon transaction, no lsu_valid_o generated.

Structure
REQ-027 Width encodings, BUS_BASE default, state encodings SHALL live in shared define.v.
REQ-028 Lane extract/extend and store replicate/strobe SHALL be sub-module lsu_data_align (combinational); FSM, counter, latches in lsu_req_ctrl.

Verification
REQ-029 LB signed addr 0x0000_1003, dc_rdata 0x80AA_BBCC, ready after 2 cycles -> dc_req_o 2 cycles, lsu_rdata_o 0xFFFF_FF80, valid 1 cycle.
REQ-030 SH addr 0x2000_0002 data 0x0000_1234 -> single bus_req_o pulse, bus_wstrb_o 1100, bus_wdata_o 0x1234_1234, stall until ack+1.
REQ-031 LW addr 0x0000_0006 -> lsu_misalign_o=1 one cycle, dc_req_o/bus_req_o stay 0, stall 0.
REQ-032 LHU addr 0x3000_0000, no ack -> timeout after 255 BUS_WAIT cycles, RESP with lsu_err_o=1.
REQ-033 Back-to-back LW 0x100 then SW 0x2000_0000 -> second accepted cycle after RESP, exactly one request each.
REQ-034 flush_i mid DC_WAIT -> transaction completes, lsu_valid_o stays 0; rst_n low mid BUS_WAIT -> IDLE, outputs 0.
